// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub_pkg
// Description : Shared definitions for the bit-serial subtractor.
//               - serial_sub_state_t : FSM state encoding (IDLE/SHIFT/DONE)
//               - cnt_w()            : width of the bit counter for a given
//                                      operand width
// Revision    : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } serial_sub_state_t;

  // Counter must hold WIDTH-1; $clog2(WIDTH) bits suffice for WIDTH >= 2.
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage : serial_sub_pkg
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : full_subtractor
// Description : 1-bit full subtractor built from two half-subtractor stages.
//               diff_o = a_i ^ b_i ^ bin_i
//               bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i)
// Ports       : a_i    in  1  minuend bit
//               b_i    in  1  subtrahend bit
//               bin_i  in  1  borrow-in
//               diff_o out 1  difference bit
//               bout_o out 1  borrow-out
// Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic diff_o,
  output logic bout_o
);

  logic hs1_diff;
  logic hs1_bout;
  logic hs2_bout;

  // Stage 1: a - b
  assign hs1_diff = a_i ^ b_i;
  assign hs1_bout = ~a_i & b_i;

  // Stage 2: (a - b) - bin
  assign diff_o   = hs1_diff ^ bin_i;
  assign hs2_bout = ~hs1_diff & bin_i;

  // At most one stage can borrow, so OR merges them.
  assign bout_o   = hs1_bout | hs2_bout;

endmodule : full_subtractor
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial WIDTH-bit subtractor. Operands accepted over a
//               valid/ready handshake are processed LSB first, one bit per
//               clock, through a single full_subtractor cell and a borrow
//               flip-flop. Result diff = a - b - bin (mod 2^WIDTH) and
//               borrow-out are presented over a second valid/ready handshake.
// Parameters  : WIDTH      operand/result width, 2..64 (default 8)
// Ports       : clk        in   1      rising-edge clock
//               rst_n      in   1      asynchronous active-low reset
//               in_valid   in   1      operands valid
//               in_ready   out  1      block can accept operands (IDLE)
//               a          in   WIDTH  minuend
//               b          in   WIDTH  subtrahend
//               bin        in   1      borrow-in
//               out_valid  out  1      result valid (DONE)
//               out_ready  in   1      consumer accepts result
//               diff       out  WIDTH  difference
//               borrow     out  1      borrow-out (a < b + bin, unsigned)
//               ovf        out  1      signed overflow, present only when
//                                      SERIAL_SUB_SIGNED_EN is defined
// Macros      : SERIAL_SUB_SIGNED_EN - adds the ovf port and its logic
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_SIGNED_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_w(WIDTH);

  serial_sub_state_t state_q, state_d;

  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              br_q, br_d;
  logic              borrow_q, borrow_d;
  logic [CW-1:0]     cnt_q, cnt_d;
`ifdef SERIAL_SUB_SIGNED_EN
  logic              ovf_q, ovf_d;
`endif

  logic              cell_diff;
  logic              cell_bout;
  logic [WIDTH-1:0]  res_shifted;

  // --------------------------------------------------------------------------
  // Serial cell: always looks at the current LSBs and the borrow FF
  // --------------------------------------------------------------------------
  full_subtractor u_cell (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .bin_i  (br_q),
    .diff_o (cell_diff),
    .bout_o (cell_bout)
  );

  // New difference bit enters at the MSB so that after WIDTH shifts the
  // first (LSB) bit has arrived at position 0.
  assign res_shifted = {cell_diff, res_q[WIDTH-1:1]};

  // --------------------------------------------------------------------------
  // State / datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
`ifdef SERIAL_SUB_SIGNED_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      br_q     <= br_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
`ifdef SERIAL_SUB_SIGNED_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state / datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    br_d     = br_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
`ifdef SERIAL_SUB_SIGNED_EN
    ovf_d    = ovf_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          res_d   = '0;
          cnt_d   = CW'(WIDTH - 1);
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = res_shifted;
        br_d  = cell_bout;
        if (cnt_q == '0) begin
          // Final bit: the cell is operating on the MSB, so br_q is the
          // borrow into the MSB and cell_bout the borrow out of it.
          diff_d   = res_shifted;
          borrow_d = cell_bout;
`ifdef SERIAL_SUB_SIGNED_EN
          ovf_d    = br_q ^ cell_bout;
`endif
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake outputs depend on state only.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign diff      = diff_q;
  assign borrow    = borrow_q;
`ifdef SERIAL_SUB_SIGNED_EN
  assign ovf       = ovf_q;
`endif

endmodule : serial_subtractor
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking bench for serial_subtractor (WIDTH=8).
//               Directed vectors with literal expectations plus randomized
//               operations checked every cycle against a cycle-stamped
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b1;
  logic         in_valid  = 1'b0;
  logic         bin       = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;
  logic         in_ready;
  logic         out_valid;
  logic         borrow;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_SIGNED_EN
  logic         ovf;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow)
`ifdef SERIAL_SUB_SIGNED_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference arithmetic
  // --------------------------------------------------------------------------
  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    longint r;
    r = longint'(x) - longint'(y) - longint'(c);
    return r[W-1:0];
  endfunction

  function automatic logic ref_borrow(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return longint'(x) < (longint'(y) + longint'(c));
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    longint r;
    r = longint'($signed(x)) - longint'($signed(y)) - longint'(c);
    return (r > (2**(W-1)) - 1) || (r < -(2**(W-1)));
  endfunction

  // --------------------------------------------------------------------------
  // Cycle-stamped model + per-cycle compare
  // phase: 0 = idle, 1 = computing (result due W edges after accept), 2 = done
  // --------------------------------------------------------------------------
  logic         mon_en = 1'b0;
  int           m_phase = 0;
  longint       cyc = 0;
  longint       acc_cyc = 0;
  logic [W-1:0] m_diff = '0, p_diff = '0;
  logic         m_borrow = 1'b0, p_borrow = 1'b0;
  logic         m_ovf = 1'b0, p_ovf = 1'b0;
  logic         s_rst, s_iv, s_bin, s_or;
  logic [W-1:0] s_a, s_b;

  always begin
    @(posedge clk);
    s_rst = rst_n; s_iv = in_valid; s_a = a; s_b = b; s_bin = bin; s_or = out_ready;
    #1;
    cyc++;
    if (mon_en) begin
      if (!s_rst) begin
        m_phase = 0; m_diff = '0; m_borrow = 1'b0; m_ovf = 1'b0;
      end else if (m_phase == 0 && s_iv) begin
        m_phase  = 1;
        acc_cyc  = cyc;
        p_diff   = ref_diff(s_a, s_b, s_bin);
        p_borrow = ref_borrow(s_a, s_b, s_bin);
        p_ovf    = ref_ovf(s_a, s_b, s_bin);
      end else if (m_phase == 1 && (cyc - acc_cyc) == W) begin
        m_phase = 2; m_diff = p_diff; m_borrow = p_borrow; m_ovf = p_ovf;
      end else if (m_phase == 2 && s_or) begin
        m_phase = 0;
      end
      check("mon_in_ready",  in_ready,  m_phase == 0);
      check("mon_out_valid", out_valid, m_phase == 2);
      check("mon_diff",      diff,      m_diff);
      check("mon_borrow",    borrow,    m_borrow);
`ifdef SERIAL_SUB_SIGNED_EN
      check("mon_ovf",       ovf,       m_ovf);
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------------
  task automatic start_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbin);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL in_ready_timeout: got 0, expected 1 within 50 cycles");
    end
    a = xa; b = xb; bin = xbin; in_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble operands after the handshake; they must already be captured.
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
  endtask

  task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbin,
                       input int hold, output logic [W-1:0] rd, output logic rb, output int lat);
    start_op(xa, xb, xbin);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      in_valid = ($urandom_range(0, 3) == 0);
    end
    rd = diff; rb = borrow;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      check("hold_in_ready",  in_ready,  1'b0);
      check("hold_out_valid", out_valid, 1'b1);
      check("hold_diff",      diff,      rd);
      check("hold_borrow",    borrow,    rb);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("ret_in_ready",  in_ready,  1'b1);
    check("ret_out_valid", out_valid, 1'b0);
    out_ready = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    logic [W-1:0] rd, ra, rbv;
    logic         rb, rc;
    int           lat;

    // Async reset asserted mid-cycle, before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_diff",      diff,      8'h00);
    check("rst_borrow",    borrow,    1'b0);
`ifdef SERIAL_SUB_SIGNED_EN
    check("rst_ovf",       ovf,       1'b0);
`endif
    mon_en = 1'b1;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    do_op(8'h5A, 8'h23, 1'b0, 0, rd, rb, lat);
    check("op1_diff", rd, 8'h37);
    check("op1_borrow", rb, 1'b0);
    check("op1_latency", lat, W);

    do_op(8'h10, 8'h20, 1'b0, 0, rd, rb, lat);
    check("op2_diff", rd, 8'hF0);
    check("op2_borrow", rb, 1'b1);

    do_op(8'h00, 8'h00, 1'b1, 0, rd, rb, lat);
    check("op3_diff", rd, 8'hFF);
    check("op3_borrow", rb, 1'b1);

    // Back-pressure: result held for 5 cycles with in_valid pulsing.
    do_op(8'hC3, 8'h3C, 1'b1, 5, rd, rb, lat);
    check("op4_diff", rd, 8'h86);
    check("op4_borrow", rb, 1'b0);

    // Reset while shifting with count=3 (4 edges after accept).
    start_op(8'hA5, 8'h01, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready",  in_ready,  1'b1);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_diff",      diff,      8'h00);
    check("midrst_borrow",    borrow,    1'b0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    do_op(8'h01, 8'h01, 1'b0, 0, rd, rb, lat);
    check("op5_diff", rd, 8'h00);
    check("op5_borrow", rb, 1'b0);

`ifdef SERIAL_SUB_SIGNED_EN
    do_op(8'h80, 8'h01, 1'b0, 0, rd, rb, lat);
    check("op6_diff", rd, 8'h7F);
    check("op6_ovf", ovf, 1'b1);
    do_op(8'h05, 8'h03, 1'b0, 0, rd, rb, lat);
    check("op7_diff", rd, 8'h02);
    check("op7_ovf", ovf, 1'b0);
`endif

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      ra  = W'($urandom);
      rbv = (i % 8 == 0) ? ra : W'($urandom);
      rc  = 1'($urandom);
      do_op(ra, rbv, rc, $urandom_range(0, 3), rd, rb, lat);
      check("rnd_diff",    rd,  ref_diff(ra, rbv, rc));
      check("rnd_borrow",  rb,  ref_borrow(ra, rbv, rc));
      check("rnd_latency", lat, W);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    n_cmp++; n_bad++;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_serial_subtractor
`default_nettype wire
